// File: rtl/cmp_swap_pipe.sv
// cmp_swap_pipe: pipelined compare-and-swap element for a sorting network.
// Orders two operands as (min, max) under unsigned, signed or sign-magnitude
// (BFP16) rules, behind a valid/ready elastic pipeline of 1..3 stages.
//
// valid/ready: a pair moves into a stage when the upstream valid is high and
// the stage is enabled. A stage is enabled when it is empty or its contents
// leave in the same cycle. o_ready is stage-1 enable, so it follows i_ready
// combinationally. While o_valid is high and i_ready is low, outputs hold.
//
// Optional feature macro: CMP_SWAP_CNT_EN adds the saturating o_swap_cnt.
module cmp_swap_pipe #(
    parameter int SIZE_DATA   = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_mode,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_min,
    output logic [SIZE_DATA-1:0] o_max,
    output logic                 o_swapped
`ifdef CMP_SWAP_CNT_EN
    ,
    output logic [31:0]          o_swap_cnt
`endif
);

    localparam int NIB = SIZE_DATA / 4;
    localparam int MSB = SIZE_DATA - 1;

    if (((SIZE_DATA % 4) != 0) || (SIZE_DATA < 8)) begin : g_bad_size
        $error("cmp_swap_pipe: SIZE_DATA must be a multiple of 4 and >= 8");
    end
    if ((PIPE_STAGES < 1) || (PIPE_STAGES > 3)) begin : g_bad_stages
        $error("cmp_swap_pipe: PIPE_STAGES must be 1..3");
    end

    // Map each number format onto a word whose unsigned order is the one wanted:
    // signed flips the MSB, sign-magnitude drops the sign and compares magnitude.
    function automatic logic [MSB:0] fold_word(input logic [MSB:0] x, input logic [1:0] mode);
        fold_word = x;
        if (mode == 2'b01) fold_word[MSB] = ~x[MSB];
        else if (mode == 2'b10) fold_word[MSB] = 1'b0;
    endfunction

    // 4-bit leaf cells: per-nibble B < A and B == A.
    function automatic logic [NIB-1:0] leaf_lt(input logic [MSB:0] a, input logic [MSB:0] b);
        for (int i = 0; i < NIB; i++) leaf_lt[i] = (b[4*i +: 4] < a[4*i +: 4]);
    endfunction

    function automatic logic [NIB-1:0] leaf_eq(input logic [MSB:0] a, input logic [MSB:0] b);
        for (int i = 0; i < NIB; i++) leaf_eq[i] = (b[4*i +: 4] == a[4*i +: 4]);
    endfunction

    // Fold the leaves upward: less = less_hi | (eq_hi & less_lo).
    function automatic logic reduce_lt(input logic [NIB-1:0] lt, input logic [NIB-1:0] eq);
        reduce_lt = 1'b0;
        for (int i = 0; i < NIB; i++) reduce_lt = lt[i] | (eq[i] & reduce_lt);
    endfunction

    // Final B < A decision; sign-magnitude needs the sign bits and the +0/-0 tie.
    function automatic logic decide_less(input logic lt, input logic eq, input logic [MSB:0] a,
                                         input logic [MSB:0] b, input logic [1:0] mode);
        logic both_zero;
        both_zero   = ~|a[MSB-1:0] & ~|b[MSB-1:0];
        decide_less = lt;
        if (mode == 2'b10) begin
            if (a[MSB] != b[MSB]) decide_less = b[MSB] & ~both_zero;
            else if (a[MSB])      decide_less = ~lt & ~eq;
        end
    endfunction

    // Leaf-level bundle (registered stage 1 when PIPE_STAGES >= 2).
    logic           lf_valid, lf_adv;
    logic [MSB:0]   lf_a, lf_b;
    logic [1:0]     lf_mode;
    logic [NIB-1:0] lf_lt, lf_eq;
    // Reduced bundle (registered middle stage when PIPE_STAGES == 3).
    logic           rd_valid, rd_lt, rd_eq;
    logic [MSB:0]   rd_a, rd_b;
    logic [1:0]     rd_mode;
    // Output stage.
    logic           out_en, swap_now;
    logic           out_valid_q, out_valid_d, swapped_q, swapped_d;
    logic [MSB:0]   min_q, min_d, max_q, max_d;

    if (PIPE_STAGES == 1) begin : g_lf_comb
        assign lf_valid = i_valid;
        assign lf_a     = i_data_a;
        assign lf_b     = i_data_b;
        assign lf_mode  = i_mode;
        assign lf_lt    = leaf_lt(fold_word(i_data_a, i_mode), fold_word(i_data_b, i_mode));
        assign lf_eq    = leaf_eq(fold_word(i_data_a, i_mode), fold_word(i_data_b, i_mode));
        assign o_ready  = lf_adv;
    end else begin : g_lf_reg
        logic           lf_valid_q, lf_valid_d;
        logic [MSB:0]   lf_a_q, lf_a_d, lf_b_q, lf_b_d;
        logic [1:0]     lf_mode_q, lf_mode_d;
        logic [NIB-1:0] lf_lt_q, lf_lt_d, lf_eq_q, lf_eq_d;

        assign o_ready = ~lf_valid_q | lf_adv;

        // Stage 1: capture operands, mode and leaf results on an input transfer.
        always_comb begin
            lf_valid_d = lf_valid_q;
            lf_a_d     = lf_a_q;
            lf_b_d     = lf_b_q;
            lf_mode_d  = lf_mode_q;
            lf_lt_d    = lf_lt_q;
            lf_eq_d    = lf_eq_q;
            if (o_ready) begin
                lf_valid_d = i_valid;
                if (i_valid) begin
                    lf_a_d    = i_data_a;
                    lf_b_d    = i_data_b;
                    lf_mode_d = i_mode;
                    lf_lt_d   = leaf_lt(fold_word(i_data_a, i_mode), fold_word(i_data_b, i_mode));
                    lf_eq_d   = leaf_eq(fold_word(i_data_a, i_mode), fold_word(i_data_b, i_mode));
                end
            end
        end

        // Stage 1 registers.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                lf_valid_q <= 1'b0;
                lf_a_q     <= '0;
                lf_b_q     <= '0;
                lf_mode_q  <= '0;
                lf_lt_q    <= '0;
                lf_eq_q    <= '0;
            end else begin
                lf_valid_q <= lf_valid_d;
                lf_a_q     <= lf_a_d;
                lf_b_q     <= lf_b_d;
                lf_mode_q  <= lf_mode_d;
                lf_lt_q    <= lf_lt_d;
                lf_eq_q    <= lf_eq_d;
            end
        end

        assign lf_valid = lf_valid_q;
        assign lf_a     = lf_a_q;
        assign lf_b     = lf_b_q;
        assign lf_mode  = lf_mode_q;
        assign lf_lt    = lf_lt_q;
        assign lf_eq    = lf_eq_q;
    end

    if (PIPE_STAGES == 3) begin : g_rd_reg
        logic         rd_valid_q, rd_valid_d, rd_lt_q, rd_lt_d, rd_eq_q, rd_eq_d;
        logic [MSB:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
        logic [1:0]   rd_mode_q, rd_mode_d;

        assign lf_adv = ~rd_valid_q | out_en;

        // Middle stage: register the reduced less/equal with the operands.
        always_comb begin
            rd_valid_d = rd_valid_q;
            rd_lt_d    = rd_lt_q;
            rd_eq_d    = rd_eq_q;
            rd_a_d     = rd_a_q;
            rd_b_d     = rd_b_q;
            rd_mode_d  = rd_mode_q;
            if (lf_adv) begin
                rd_valid_d = lf_valid;
                if (lf_valid) begin
                    rd_lt_d   = reduce_lt(lf_lt, lf_eq);
                    rd_eq_d   = &lf_eq;
                    rd_a_d    = lf_a;
                    rd_b_d    = lf_b;
                    rd_mode_d = lf_mode;
                end
            end
        end

        // Middle stage registers.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                rd_valid_q <= 1'b0;
                rd_lt_q    <= 1'b0;
                rd_eq_q    <= 1'b0;
                rd_a_q     <= '0;
                rd_b_q     <= '0;
                rd_mode_q  <= '0;
            end else begin
                rd_valid_q <= rd_valid_d;
                rd_lt_q    <= rd_lt_d;
                rd_eq_q    <= rd_eq_d;
                rd_a_q     <= rd_a_d;
                rd_b_q     <= rd_b_d;
                rd_mode_q  <= rd_mode_d;
            end
        end

        assign rd_valid = rd_valid_q;
        assign rd_lt    = rd_lt_q;
        assign rd_eq    = rd_eq_q;
        assign rd_a     = rd_a_q;
        assign rd_b     = rd_b_q;
        assign rd_mode  = rd_mode_q;
    end else begin : g_rd_comb
        assign lf_adv   = out_en;
        assign rd_valid = lf_valid;
        assign rd_lt    = reduce_lt(lf_lt, lf_eq);
        assign rd_eq    = &lf_eq;
        assign rd_a     = lf_a;
        assign rd_b     = lf_b;
        assign rd_mode  = lf_mode;
    end

    assign out_en   = ~out_valid_q | i_ready;
    assign swap_now = decide_less(rd_lt, rd_eq, rd_a, rd_b, rd_mode);

    // Output stage: swap mux; ties keep A first so sorting stays stable.
    always_comb begin
        out_valid_d = out_valid_q;
        swapped_d   = swapped_q;
        min_d       = min_q;
        max_d       = max_q;
        if (out_en) begin
            out_valid_d = rd_valid;
            if (rd_valid) begin
                swapped_d = swap_now;
                min_d     = swap_now ? rd_b : rd_a;
                max_d     = swap_now ? rd_a : rd_b;
            end
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid_q <= 1'b0;
            swapped_q   <= 1'b0;
            min_q       <= '0;
            max_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            swapped_q   <= swapped_d;
            min_q       <= min_d;
            max_q       <= max_d;
        end
    end

    assign o_valid   = out_valid_q;
    assign o_swapped = swapped_q;
    assign o_min     = min_q;
    assign o_max     = max_q;

`ifdef CMP_SWAP_CNT_EN
    logic [31:0] swap_cnt_q, swap_cnt_d;

    // Count swapped pairs as they leave; stick at all-ones instead of wrapping.
    always_comb begin
        swap_cnt_d = swap_cnt_q;
        if (out_valid_q && i_ready && swapped_q && !(&swap_cnt_q)) swap_cnt_d = swap_cnt_q + 32'd1;
    end

    // Swap counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) swap_cnt_q <= '0;
        else       swap_cnt_q <= swap_cnt_d;
    end

    assign o_swap_cnt = swap_cnt_q;
`endif

endmodule
